// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry, opcodes, bank word layout and sequencer state encoding
// for the 5x5 x 8-bit register bank command path.
package matrix_pkg;
    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int DATA_W = 8;
    localparam int BANK_W = DATA_W + 6;
    localparam int COL_LSB = 0;
    localparam int ROW_LSB = 3;
    localparam int DATA_LSB = 6;
    localparam logic [2:0] ROW_MAX = 3'(ROWS - 1);
    localparam logic [2:0] COL_MAX = 3'(COLS - 1);
    localparam logic [1:0] OP_WRITE_CELL = 2'b00;
    localparam logic [1:0] OP_FILL_ROW = 2'b01;
    localparam logic [1:0] OP_FILL_ALL = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN = 2'd1,
        S_DONE = 2'd2
    } seqStateT;

    function automatic logic [BANK_W-1:0] packWord(
        input logic [DATA_W-1:0] data,
        input logic [2:0] row,
        input logic [2:0] col
    );
        logic [BANK_W-1:0] word;
        word = '0;
        word[DATA_LSB +: DATA_W] = data;
        word[ROW_LSB +: 3] = row;
        word[COL_LSB +: 3] = col;
        return word;
    endfunction
endpackage

// File: rtl/cell_index_counter.sv
// cell_index_counter: row/col walker for bank fills; col wraps into the next row
// unless the row is locked, and 'last' marks the terminal cell so the walk never overruns.
module cell_index_counter
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       step,
    input  logic       lockRow,
    input  logic [2:0] rowIn,
    input  logic [2:0] colIn,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);
    logic rowLocked;

    assign last = (col == COL_MAX) && (rowLocked || row == ROW_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
            rowLocked <= 1'b0;
        end else if (load) begin
            row <= rowIn;
            col <= colIn;
            rowLocked <= lockRow;
        end else if (step && !last) begin
            col <= (col == COL_MAX) ? 3'd0 : col + 3'd1;
            row <= (col == COL_MAX && !rowLocked) ? row + 3'd1 : row;
        end
    end
endmodule

// File: rtl/matrix_write_sequencer.sv
// matrix_write_sequencer: valid/ready command front-end sequencing writes and clears into
// the register bank; bank-side signals launch on negedge so the gated bank clock sees one clean pulse per write.
module matrix_write_sequencer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_row,
    input  logic [2:0]        cmd_col,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [BANK_W-1:0] bank_data_in,
    output logic              bank_write,
    output logic              bank_clear,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);
    seqStateT state;
    logic [1:0] op;
    logic [DATA_W-1:0] data;
    logic [2:0] row, col;
    logic last, accept, badCmd, armed, singleOp;

    assign accept = cmd_valid && state == S_IDLE;
    assign badCmd = (cmd_op == OP_WRITE_CELL && (cmd_row > ROW_MAX || cmd_col > COL_MAX))
                 || (cmd_op == OP_FILL_ROW && cmd_row > ROW_MAX);
    assign armed = state == S_RUN;
    assign singleOp = op == OP_WRITE_CELL || op == OP_CLEAR;
    assign busy = !cmd_ready;

    cell_index_counter idx (
        .clk(clk),
        .reset_n(reset_n),
        .load(accept),
        .step(armed),
        .lockRow(cmd_op == OP_FILL_ROW),
        .rowIn(cmd_op == OP_FILL_ALL ? 3'd0 : cmd_row),
        .colIn(cmd_op == OP_WRITE_CELL ? cmd_col : 3'd0),
        .row(row),
        .col(col),
        .last(last)
    );

    // err_clr is applied first so a rejection on the same edge wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cmd_ready <= 1'b1;
            done <= 1'b0;
            err <= 1'b0;
            op <= OP_WRITE_CELL;
            data <= '0;
        end else begin
            done <= 1'b0;
            if (err_clr) err <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    cmd_ready <= 1'b0;
                    op <= cmd_op;
                    data <= cmd_data;
                    state <= badCmd ? S_DONE : S_RUN;
                    done <= badCmd;
                    if (badCmd) err <= 1'b1;
                end
                S_RUN: if (singleOp || last) begin
                    state <= S_DONE;
                    done <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // strobe armed for the next posedge rises here and drops a half cycle after it
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_data_in <= '0;
            bank_write <= 1'b0;
            bank_clear <= 1'b0;
        end else begin
            bank_write <= armed && op != OP_CLEAR;
            bank_clear <= armed && op == OP_CLEAR;
            if (armed && op != OP_CLEAR) bank_data_in <= packWord(data, row, col);
        end
    end
endmodule
